// File: rtl/cell_scheduler.sv
// Frame sequencer: walks every CELL_N x CELL_N window in raster order, gathers cells from two
// frame buffers, hands them to the cell processor and writes results back. Optional abort_i via CELL_SCHED_ABORT_EN.
module cell_scheduler #(
    parameter int IMG_W  = 640,
    parameter int IMG_H  = 480,
    parameter int CELL_N = 3,
    parameter int ADDR_W = $clog2(IMG_W*IMG_H)
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         start_i,
    input  logic [3:0]                   opcode_i,
    input  logic [7:0]                   user_i,
    output logic                         busy_o,
    output logic                         done_o,
    output logic                         err_o,
    output logic                         rd_en_o,
    output logic [ADDR_W-1:0]            rd_addr_o,
    input  logic [23:0]                  rd_data_a_i,
    input  logic [23:0]                  rd_data_b_i,
    output logic                         cell_valid_o,
    input  logic                         cell_ready_i,
    output logic [24*CELL_N*CELL_N-1:0]  cell_a_o,
    output logic [24*CELL_N*CELL_N-1:0]  cell_b_o,
    output logic [3:0]                   opcode_o,
    output logic [7:0]                   user_o,
    input  logic                         res_valid_i,
    input  logic [23:0]                  res_pixel_i,
    output logic                         wr_en_o,
    output logic [ADDR_W-1:0]            wr_addr_o,
    output logic [23:0]                  wr_data_o
`ifdef CELL_SCHED_ABORT_EN
    ,
    input  logic                         abort_i
`endif
);
    localparam int NN = CELL_N*CELL_N;
    localparam int KW = $clog2(NN+1);
    localparam int XW = $clog2(IMG_W+1);
    localparam int YW = $clog2(IMG_H+1);
    localparam int CW = $clog2(CELL_N+1);
    localparam logic [XW-1:0]     X_LAST = XW'(IMG_W-CELL_N);
    localparam logic [YW-1:0]     Y_LAST = YW'(IMG_H-CELL_N);
    localparam logic [KW-1:0]     K_LAST = KW'(NN);
    localparam logic [CW-1:0]     C_LAST = CW'(CELL_N-1);
    localparam logic [ADDR_W-1:0] A_ROW  = ADDR_W'(IMG_W);
    localparam logic [ADDR_W-1:0] A_WRAP = ADDR_W'(CELL_N);

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_ISSUE, S_WAIT, S_WRITE, S_DONE} state_t;

    state_t              r_state, w_state_next;
    logic                w_abort, w_start_ok, w_last_win;
    logic [KW-1:0]       r_k;
    logic [CW-1:0]       r_fcol;
    logic [ADDR_W-1:0]   r_row_off, r_base, r_wr_addr;
    logic [XW-1:0]       r_x;
    logic [YW-1:0]       r_y;
    logic [3:0]          r_opcode;
    logic [7:0]          r_user;
    logic [23:0]         r_res;
    logic                r_err;

`ifdef CELL_SCHED_ABORT_EN
    assign w_abort = abort_i;
`else
    assign w_abort = 1'b0;
`endif

    assign w_start_ok = start_i && (opcode_i <= 4'd11);
    assign w_last_win = (r_x == X_LAST) && (r_y == Y_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        if (w_abort && r_state != S_IDLE) begin
            w_state_next = S_IDLE;
        end else begin
            unique case (r_state)
                S_IDLE:  if (w_start_ok) w_state_next = S_FETCH;
                S_FETCH: if (r_k == K_LAST) w_state_next = S_ISSUE;
                S_ISSUE: if (cell_ready_i) w_state_next = S_WAIT;
                S_WAIT:  if (res_valid_i) w_state_next = S_WRITE;
                S_WRITE: w_state_next = w_last_win ? S_DONE : S_FETCH;
                S_DONE:  w_state_next = S_IDLE;
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    always_comb begin
        busy_o       = (r_state != S_IDLE) && (r_state != S_DONE) && !w_abort;
        done_o       = (r_state == S_DONE) && !w_abort;
        rd_en_o      = (r_state == S_FETCH) && (r_k != K_LAST) && !w_abort;
        cell_valid_o = (r_state == S_ISSUE) && !w_abort;
        wr_en_o      = (r_state == S_WRITE) && !w_abort;
        err_o        = r_err;
        rd_addr_o    = r_base + r_row_off + ADDR_W'(r_fcol);
        wr_addr_o    = r_wr_addr;
        wr_data_o    = r_res;
        opcode_o     = r_opcode;
        user_o       = r_user;
    end

    // Output address equals the window ordinal because windows are visited in raster order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_k       <= '0;
            r_fcol    <= '0;
            r_row_off <= '0;
            r_base    <= '0;
            r_wr_addr <= '0;
            r_x       <= '0;
            r_y       <= '0;
            r_opcode  <= '0;
            r_user    <= '0;
            r_res     <= '0;
            r_err     <= 1'b0;
        end else begin
            r_err <= (r_state == S_IDLE) && start_i && (opcode_i > 4'd11);
            unique case (r_state)
                S_IDLE: begin
                    if (w_start_ok) begin
                        r_opcode  <= opcode_i;
                        r_user    <= user_i;
                        r_k       <= '0;
                        r_fcol    <= '0;
                        r_row_off <= '0;
                        r_base    <= '0;
                        r_wr_addr <= '0;
                        r_x       <= '0;
                        r_y       <= '0;
                    end
                end
                S_FETCH: begin
                    if (r_k == K_LAST) begin
                        r_k       <= '0;
                        r_fcol    <= '0;
                        r_row_off <= '0;
                    end else begin
                        r_k <= r_k + KW'(1);
                        if (r_fcol == C_LAST) begin
                            r_fcol    <= '0;
                            r_row_off <= r_row_off + A_ROW;
                        end else begin
                            r_fcol <= r_fcol + CW'(1);
                        end
                    end
                end
                S_WAIT: if (res_valid_i) r_res <= res_pixel_i;
                S_WRITE: begin
                    r_wr_addr <= r_wr_addr + ADDR_W'(1);
                    if (r_x == X_LAST) begin
                        r_x    <= '0;
                        r_y    <= r_y + YW'(1);
                        r_base <= r_base + A_WRAP;
                    end else begin
                        r_x    <= r_x + XW'(1);
                        r_base <= r_base + ADDR_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Element gi is read at fetch index gi, so its data lands while r_k == gi+1.
    generate
        for (genvar gi = 0; gi < NN; gi++) begin : g_cell
            logic [23:0] r_pix_a, r_pix_b;
            logic        w_cap;
            assign w_cap = (r_state == S_FETCH) && (r_k == KW'(gi+1)) && !w_abort;
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_pix_a <= '0;
                    r_pix_b <= '0;
                end else if (w_cap) begin
                    r_pix_a <= rd_data_a_i;
                    r_pix_b <= rd_data_b_i;
                end
            end
            assign cell_a_o[gi*24 +: 24] = r_pix_a;
            assign cell_b_o[gi*24 +: 24] = r_pix_b;
        end
    endgenerate
endmodule
